// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display back end.
// Segment patterns are active-high with bit0=a through bit6=g.
package sseg_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    // Maps an active-high segment vector onto the pin level for the chosen polarity.
    function automatic logic [6:0] pol_seg(input logic [6:0] v, input logic act_low);
        return act_low ? ~v : v;
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// BCD digit to active-high 7-segment pattern; codes 10-15 render as a dash.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pattern lookup
    always_comb begin
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed driver for NDIG common-anode digits sharing one segment bus,
// with per-frame input latching, leading-zero blanking and an anode ghost guard.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter int NDIG        = 4,
    parameter int BLANK_CYC   = 16,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4*NDIG-1:0] digits_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              blank_lz,
    output logic [6:0]        sseg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
    localparam int PW  = $clog2(DIV);
    localparam int IW  = $clog2(NDIG);

    localparam logic            SEG_LOW  = (SEG_ACT_LOW != 0);
    localparam logic            AN_LOW   = (AN_ACT_LOW != 0);
    localparam logic [6:0]      SEG_IDLE = pol_seg(7'h00, SEG_LOW);
    localparam logic [NDIG-1:0] AN_IDLE  = {NDIG{AN_LOW}};

    logic [PW-1:0]     pcnt_r;
    logic [IW-1:0]     idx_r;
    logic [4*NDIG-1:0] shadow_r;
    logic [NDIG-1:0]   dp_sh_r;
    logic              load_pend_r;

    logic [6:0]        sseg_r;
    logic              dp_r;
    logic [NDIG-1:0]   an_r;
    logic              frame_done_r;

    logic              slot_end_s;
    logic              last_idx_s;
    logic              capture_s;
    logic [3:0]        dig_arr_s [NDIG];
    logic [3:0]        code_s;
    logic [6:0]        seg_s;
    logic [NDIG-1:0]   blank_s;
    logic              zero_run_s;
    logic [NDIG-1:0]   an_act_s;

    assign slot_end_s = (pcnt_r == PW'(DIV - 1));
    assign last_idx_s = (idx_r == IW'(NDIG - 1));
    assign capture_s  = (slot_end_s && last_idx_s) || load_pend_r;

    for (genvar g = 0; g < NDIG; g++) begin : g_unpack
        assign dig_arr_s[g] = shadow_r[4*g +: 4];
    end

    assign code_s = dig_arr_s[idx_r];

    sseg_decode u_decode (
        .code (code_s),
        .seg  (seg_s)
    );

    // Leading-zero run from the top digit down; a set dp ends the run, digit 0 never blanks
    always_comb begin
        zero_run_s = 1'b1;
        blank_s    = {NDIG{1'b0}};
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (dig_arr_s[i] == 4'h0) & ~dp_sh_r[i];
            blank_s[i] = zero_run_s & blank_lz;
        end
    end

    // Active-high anode select with ghost guard at the head of every slot
    always_comb begin
        if ((pcnt_r < PW'(BLANK_CYC)) || blank_s[idx_r]) begin
            an_act_s = {NDIG{1'b0}};
        end else begin
            an_act_s = NDIG'(1'b1) << idx_r;
        end
    end

    // Prescaler, digit index and once-per-frame shadow capture
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_r      <= {PW{1'b0}};
            idx_r       <= {IW{1'b0}};
            shadow_r    <= {(4*NDIG){1'b0}};
            dp_sh_r     <= {NDIG{1'b0}};
            load_pend_r <= 1'b1;
        end else begin
            if (slot_end_s) begin
                pcnt_r <= {PW{1'b0}};
                idx_r  <= last_idx_s ? {IW{1'b0}} : idx_r + IW'(1'b1);
            end else begin
                pcnt_r <= pcnt_r + PW'(1'b1);
            end
            if (capture_s) begin
                shadow_r <= digits_in;
                dp_sh_r  <= dp_in;
            end
            load_pend_r <= 1'b0;
        end
    end

    // Output registers with polarity applied at the pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sseg_r       <= SEG_IDLE;
            dp_r         <= SEG_LOW;
            an_r         <= AN_IDLE;
            frame_done_r <= 1'b0;
        end else begin
            sseg_r       <= pol_seg(seg_s, SEG_LOW);
            dp_r         <= dp_sh_r[idx_r] ^ SEG_LOW;
            an_r         <= an_act_s ^ AN_IDLE;
            frame_done_r <= slot_end_s && last_idx_s;
        end
    end

    assign sseg       = sseg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench for sseg_scan_mux: expected digit slots are queued by the
// stimulus and consumed by a monitor that watches the anode bus.
module tb_sseg_scan_mux;

    localparam logic [6:0] L0 = 7'b1000000;
    localparam logic [6:0] L1 = 7'b1111001;
    localparam logic [6:0] L2 = 7'b0100100;
    localparam logic [6:0] L3 = 7'b0110000;
    localparam logic [6:0] L4 = 7'b0011001;
    localparam logic [6:0] L6 = 7'b0000010;
    localparam logic [6:0] L7 = 7'b1111000;
    localparam logic [6:0] L8 = 7'b0000000;
    localparam logic [6:0] LD = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  sseg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   fd_cnt  = 0;
    int   fd_base = 0;
    bit   mon_en  = 1'b0;

    sseg_scan_mux #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .NDIG        (4),
        .BLANK_CYC   (2),
        .SEG_ACT_LOW (1),
        .AN_ACT_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .sseg       (sseg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.an = a; e.sseg = s; e.dp = d;
        sb_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_an"},   32'(an),         32'h0000000F);
        chk({name, "_sseg"}, 32'(sseg),       32'h0000007F);
        chk({name, "_dp"},   32'(dp),         32'h00000001);
        chk({name, "_fd"},   32'(frame_done), 32'h00000000);
    endtask

    task automatic begin_test(input logic [15:0] d, input logic [3:0] p, input logic b);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        digits_in = d;
        dp_in     = p;
        blank_lz  = b;
        fd_base   = fd_cnt;
        reset     = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic end_test(input string name, input int frames);
        @(negedge clk);
        #1;
        chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'h0);
        chk({name, "_frames"},   32'(fd_cnt - fd_base), 32'(frames));
    endtask

    // Monitor: each slot start pops one expectation; also checks slot timing and frame_done phase
    initial begin
        int   cyc = 0;
        int   cyc_n;
        int   run_len = 0;
        bit   act;
        bit   prev_act = 1'b0;
        logic [3:0] run_an = 4'hF;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc_n = reset ? 0 : cyc + 1;
                act   = (an != 4'hF);
                if (frame_done) begin
                    fd_cnt++;
                    chk("fd_phase", 32'(cyc_n % 40), 32'd1);
                end
                if (act && !prev_act) begin
                    chk("slot_phase", 32'(cyc_n % 10), 32'd4);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_slot", 32'(an), 32'h0000000F);
                    end else begin
                        e = sb_q.pop_front();
                        chk("slot_an",   32'(an),   32'(e.an));
                        chk("slot_sseg", 32'(sseg), 32'(e.sseg));
                        chk("slot_dp",   32'(dp),   32'(e.dp));
                    end
                    run_an  = an;
                    run_len = 1;
                end else if (act && prev_act) begin
                    run_len++;
                    chk("an_stable", 32'(an), 32'(run_an));
                end else if (!act && prev_act && !reset) begin
                    chk("slot_len", 32'(run_len), 32'd8);
                end
                prev_act = act;
                cyc      = cyc_n;
            end
        end
    end

    initial begin
        // Reset held for three clocks
        digits_in = 16'h1234;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_idle("reset_hold");
        end
        mon_en = 1'b1;

        // Plain scan of 1234 over two frames
        repeat (2) begin
            push(4'b1110, L4, 1'b1);
            push(4'b1101, L3, 1'b1);
            push(4'b1011, L2, 1'b1);
            push(4'b0111, L1, 1'b1);
        end
        begin_test(16'h1234, 4'b0000, 1'b0);
        run_cycles(81);
        end_test("scan_1234", 2);

        // Leading-zero blanking hides digits 3 and 2
        push(4'b1110, L0, 1'b1);
        push(4'b1101, L7, 1'b1);
        begin_test(16'h0070, 4'b0000, 1'b1);
        run_cycles(41);
        end_test("lz_0070", 1);

        // A decimal point on digit 2 stops the blanking there
        push(4'b1110, L0, 1'b1);
        push(4'b1101, L7, 1'b1);
        push(4'b1011, L0, 1'b0);
        begin_test(16'h0070, 4'b0100, 1'b1);
        run_cycles(41);
        end_test("lz_dp", 1);

        // Mid-frame input change shows only from the following frame
        repeat (4) push(4'b0000, L1, 1'b1);
        sb_q[0].an = 4'b1110; sb_q[1].an = 4'b1101; sb_q[2].an = 4'b1011; sb_q[3].an = 4'b0111;
        push(4'b1110, L2, 1'b1);
        push(4'b1101, L2, 1'b1);
        push(4'b1011, L2, 1'b1);
        push(4'b0111, L2, 1'b1);
        begin_test(16'h1111, 4'b0000, 1'b0);
        run_cycles(15);
        digits_in = 16'h2222;
        run_cycles(66);
        end_test("no_tear", 2);

        // Non-BCD nibble renders a dash; zeros above it are blanked
        push(4'b1110, LD, 1'b1);
        begin_test(16'h000B, 4'b0000, 1'b1);
        run_cycles(41);
        end_test("dash", 1);

        // Reset during digit 2's slot, then a fresh capture restarting at digit 0
        push(4'b1110, L8, 1'b1);
        push(4'b1101, L7, 1'b1);
        push(4'b1011, L6, 1'b1);
        begin_test(16'h5678, 4'b0000, 1'b0);
        run_cycles(25);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset");
        chk("mid_reset_sb_empty", 32'(sb_q.size()), 32'h0);
        chk("mid_reset_frames", 32'(fd_cnt - fd_base), 32'h0);
        push(4'b1110, L1, 1'b1);
        push(4'b1101, L2, 1'b1);
        push(4'b1011, L3, 1'b1);
        push(4'b0111, L4, 1'b1);
        begin_test(16'h4321, 4'b0000, 1'b0);
        run_cycles(41);
        end_test("after_reset", 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
